// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with an integrated issue scoreboard.
// NRD combinational read ports with optional same-cycle write bypass, NWR
// write ports (highest port index wins on address collisions), and one busy
// bit per register that issue sets and writeback clears.
module regfile_mp_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NWR-1:0]      sb_set_en,
   input  logic [NWR*AW-1:0]   sb_set_addr,
   output logic [NREGS-1:0]    busy_vec
);

   // Elaboration-time parameter sanity checks
   if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
      $error("regfile_mp_sb: NREGS must be a power of two >= 2");
   end
   if (NRD < 1 || NWR < 1) begin : g_bad_ports
      $error("regfile_mp_sb: NRD and NWR must be >= 1");
   end
   if (XLEN < 1) begin : g_bad_xlen
      $error("regfile_mp_sb: XLEN must be >= 1");
   end
   if ((ZERO_REG != 0 && ZERO_REG != 1) || (BYPASS != 0 && BYPASS != 1)) begin : g_bad_flags
      $error("regfile_mp_sb: ZERO_REG and BYPASS must be 0 or 1");
   end

   // Architectural state, one element per register (each driven once below)
   logic [XLEN-1:0] rf [NREGS];

   genvar gi;

   // Per-register storage and busy bit
   for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
         // x0 is hard-wired: never written, never busy
         assign rf[gi]       = '0;
         assign busy_vec[gi] = 1'b0;
      end else begin : g_live
         logic [XLEN-1:0] val_reg;
         logic [XLEN-1:0] val_next;
         logic            busy_reg;
         logic            busy_next;
         logic            set_hit;
         logic            clr_hit;

         // Next value: later write ports override earlier ones; a new issue
         // (set) outranks a writeback (clear) of an older producer
         always_comb begin
            val_next = val_reg;
            set_hit  = 1'b0;
            clr_hit  = 1'b0;
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(gi)) begin
                  val_next = wr_data[j*XLEN +: XLEN];
                  clr_hit  = 1'b1;
               end
               if (sb_set_en[j] && sb_set_addr[j*AW +: AW] == AW'(gi)) begin
                  set_hit = 1'b1;
               end
            end
            busy_next = busy_reg;
            if (set_hit) begin
               busy_next = 1'b1;
            end else if (clr_hit) begin
               busy_next = 1'b0;
            end
         end

         // State update; reset clears immediately and drops that cycle's writes
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               val_reg  <= '0;
               busy_reg <= 1'b0;
            end else begin
               val_reg  <= val_next;
               busy_reg <= busy_next;
            end
         end

         assign rf[gi]       = val_reg;
         assign busy_vec[gi] = busy_reg;
      end
   end

   // Read ports
   for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            busy;
      logic            byp;

      assign addr = rd_addr[gi*AW +: AW];

      // Zero register first, then highest-index matching write, then storage;
      // bypass is suppressed under reset so outputs reflect the cleared state
      always_comb begin
         data = rf[addr];
         byp  = 1'b0;
         if (BYPASS != 0 && !reset) begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && wr_addr[j*AW +: AW] == addr) begin
                  data = wr_data[j*XLEN +: XLEN];
                  byp  = 1'b1;
               end
            end
         end
         busy = busy_vec[addr] & ~byp;
         if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
            busy = 1'b0;
         end
      end

      assign rd_data[gi*XLEN +: XLEN] = data;
      assign rd_busy[gi]              = busy;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters): directed
// scenarios followed by random traffic, compared against a behavioural model.
module tb_regfile_mp_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR-1:0]      sb_set_en;
   logic [NWR*AW-1:0]   sb_set_addr;
   logic [NREGS-1:0]    busy_vec;

   // Unpacked stimulus views
   logic [AW-1:0]   ra [NRD];
   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   logic            we [NWR];
   logic [AW-1:0]   sa [NWR];
   logic            se [NWR];

   assign rd_addr     = {ra[1], ra[0]};
   assign wr_addr     = {wa[1], wa[0]};
   assign wr_data     = {wd[1], wd[0]};
   assign wr_en       = {we[1], we[0]};
   assign sb_set_addr = {sa[1], sa[0]};
   assign sb_set_en   = {se[1], se[0]};

   // Reference model: architectural values and busy flags
   logic [XLEN-1:0] m_rf   [NREGS];
   bit              m_busy [NREGS];

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   regfile_mp_sb dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .busy_vec    (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      for (int p = 0; p < NRD; p++) ra[p] = '0;
      for (int j = 0; j < NWR; j++) begin
         wa[j] = '0; wd[j] = '0; we[j] = 1'b0; sa[j] = '0; se[j] = 1'b0;
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < NREGS; a++) begin
         m_rf[a] = '0; m_busy[a] = 1'b0;
      end
   endtask

   // What a read of address a should return this cycle
   function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
      logic [31:0] v;
      if (reset || a == 0) return 32'h0;
      v = m_rf[a];
      for (int j = 0; j < NWR; j++) if (we[j] && wa[j] == a) v = wd[j];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (reset || a == 0) return 1'b0;
      for (int j = 0; j < NWR; j++) if (we[j] && wa[j] == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [31:0] exp_busy_vec();
      logic [31:0] v;
      for (int a = 0; a < NREGS; a++) v[a] = m_busy[a];
      return v;
   endfunction

   // Compare every output against the model at the current instant
   task automatic check_outputs(input string tag);
      for (int p = 0; p < NRD; p++) begin
         chk($sformatf("%s_rd_data%0d", tag, p), rd_data[p*XLEN +: XLEN], exp_data(ra[p]));
         chk($sformatf("%s_rd_busy%0d", tag, p), 32'(rd_busy[p]), 32'(exp_busy(ra[p])));
      end
      chk($sformatf("%s_busy_vec", tag), busy_vec, exp_busy_vec());
   endtask

   // Apply the model's clock-edge rules to the currently driven inputs
   task automatic model_edge();
      bit set_hit, clr_hit;
      for (int j = 0; j < NWR; j++) if (we[j] && wa[j] != 0) m_rf[wa[j]] = wd[j];
      for (int a = 1; a < NREGS; a++) begin
         set_hit = 0; clr_hit = 0;
         for (int j = 0; j < NWR; j++) begin
            if (se[j] && sa[j] == a) set_hit = 1;
            if (we[j] && wa[j] == a) clr_hit = 1;
         end
         if (set_hit) m_busy[a] = 1'b1;
         else if (clr_hit) m_busy[a] = 1'b0;
      end
   endtask

   // One transaction: inputs already driven at posedge+1; check mid-cycle,
   // clock the edge, update the model
   task automatic step(input string tag);
      #3;
      check_outputs(tag);
      $display("txn %0d %s ra=%0d/%0d we=%b wa=%0d/%0d se=%b sa=%0d/%0d rd=%h/%h busy=%b bv=%h",
               txn, tag, ra[0], ra[1], {we[1], we[0]}, wa[0], wa[1], {se[1], se[0]},
               sa[0], sa[1], rd_data[31:0], rd_data[63:32], rd_busy, busy_vec);
      txn++;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      idle();
      model_clear();
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1) reset state on every address and port
      for (int a = 0; a < NREGS; a++) begin
         ra[0] = AW'(a); ra[1] = AW'(NREGS - 1 - a);
         #1;
         chk("rst_data0", rd_data[31:0], 32'h0);
         chk("rst_data1", rd_data[63:32], 32'h0);
         chk("rst_busy", 32'(rd_busy), 32'h0);
      end
      chk("rst_busy_vec", busy_vec, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 2) write x5, read back on both ports
      idle(); we[0] = 1; wa[0] = 5; wd[0] = 32'hDEADBEEF;
      step("t2_wr");
      idle(); ra[0] = 5; ra[1] = 5;
      #2;
      chk("t2_x5_p0", rd_data[31:0], 32'hDEADBEEF);
      chk("t2_x5_p1", rd_data[63:32], 32'hDEADBEEF);
      step("t2_rd");

      // 3) two ports writing x7: higher port wins, bypass visible same cycle
      idle(); we[0] = 1; wa[0] = 7; wd[0] = 32'h11; we[1] = 1; wa[1] = 7; wd[1] = 32'h22;
      ra[0] = 7;
      #2;
      chk("t3_bypass", rd_data[31:0], 32'h22);
      step("t3_wr");
      idle(); ra[1] = 7;
      #2;
      chk("t3_stored", rd_data[63:32], 32'h22);
      step("t3_rd");

      // 4) x0 ignores writes and busy sets
      idle(); we[0] = 1; wa[0] = 0; wd[0] = 32'hFFFFFFFF; se[1] = 1; sa[1] = 0; ra[0] = 0;
      #2;
      chk("t4_x0_same", rd_data[31:0], 32'h0);
      step("t4_wr");
      idle(); ra[0] = 0;
      #2;
      chk("t4_x0_next", rd_data[31:0], 32'h0);
      chk("t4_busy0", 32'(busy_vec[0]), 32'h0);
      step("t4_rd");

      // 5) scoreboard set, bypassed clear, set beats clear
      idle(); se[0] = 1; sa[0] = 9;
      step("t5_set");
      idle(); ra[0] = 9;
      #2;
      chk("t5_busy", 32'(rd_busy[0]), 32'h1);
      step("t5_wait");
      idle(); ra[0] = 9; we[1] = 1; wa[1] = 9; wd[1] = 32'h1234;
      #2;
      chk("t5_wb_busy", 32'(rd_busy[0]), 32'h0);
      chk("t5_wb_data", rd_data[31:0], 32'h1234);
      step("t5_wb");
      idle();
      #2;
      chk("t5_cleared", 32'(busy_vec[9]), 32'h0);
      step("t5_idle");
      idle(); se[1] = 1; sa[1] = 9; we[0] = 1; wa[0] = 9; wd[0] = 32'h1234;
      step("t5_both");
      idle(); ra[0] = 9;
      #2;
      chk("t5_set_wins", busy_vec, 32'h0000_0200);

      // 6) asynchronous reset between edges; writes during reset are lost
      reset = 1'b1;
      #1;
      model_clear();
      chk("t6_busy_vec", busy_vec, 32'h0);
      chk("t6_x9", rd_data[31:0], 32'h0);
      we[0] = 1; wa[0] = 3; wd[0] = 32'hCAFE; ra[1] = 3;
      @(posedge clk);
      #1;
      chk("t6_wr_lost", rd_data[63:32], 32'h0);
      idle();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      idle(); ra[0] = 3; ra[1] = 9;
      step("t6_after");

      // Random traffic, biased to a few hot registers so ports collide
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NRD; p++)
            ra[p] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
         for (int j = 0; j < NWR; j++) begin
            we[j] = ($urandom_range(0, 2) == 0);
            wa[j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
            wd[j] = $urandom;
            se[j] = ($urandom_range(0, 2) == 0);
            sa[j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
         end
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
